convolution_kxk_stream: RTL

//  Parametrised KxK convolution engine, successor to the fixed 3x3 PE chain.
//  - Holds a loadable KxK weight file.
//  - Consumes one window element per accepted beat and accumulates K*K products.
//  - Adds an incoming partial sum, then saturates (optional ReLU).
//  - Emits one result per window over a valid/ready stream. Sits between the

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_sat_relu.sv | 48 ++++
 rtl/convolution_kxk_stream.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared state encoding, width helpers and saturation bounds for
//               the KxK convolution stream engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_LOAD  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;

    // Worst-case K*K product sum plus one guard bit.
    function automatic int acc_bw(input int k, input int x_bw, input int w_bw);
        return x_bw + w_bw + $clog2(k * k) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic longint sat_max(input int o_bw);
        return (longint'(1) <<< (o_bw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int o_bw);
        return -(longint'(1) <<< (o_bw - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_sat_relu.sv
// ============================================================================
// Module      : conv_sat_relu
// Description : Combinational signed clip to O_BW with optional ReLU; o_sat
//               flags that the clip engaged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sat_relu
    import conv_pkg::*;
#(
    parameter int IN_BW = 22,
    parameter int O_BW  = 19,
    parameter int RELU  = 0
) (
    input  logic [IN_BW-1:0] i_in,
    output logic [O_BW-1:0]  o_out,
    output logic             o_sat
);

    localparam longint c_max = sat_max(O_BW);
    localparam longint c_min = sat_min(O_BW);

    logic signed [63:0] w_ext;
    logic signed [63:0] w_clip;

    assign w_ext = 64'($signed(i_in));

    always_comb begin
        o_sat  = 1'b0;
        w_clip = w_ext;
        if (w_ext > c_max) begin
            w_clip = c_max;
            o_sat  = 1'b1;
        end else if (w_ext < c_min) begin
            w_clip = c_min;
            o_sat  = 1'b1;
        end
        o_out = w_clip[O_BW-1:0];
        // ReLU acts after the clip, so a clipped negative still reports o_sat.
        if (RELU != 0 && w_clip < 0) begin
            o_out = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/convolution_kxk_stream.sv
// ============================================================================
// Module      : convolution_kxk_stream
// Description : KxK convolution engine: loadable weight file, 2-stage MAC pipe,
//               partial-sum add, saturation and valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module convolution_kxk_stream
    import conv_pkg::*;
#(
    parameter int K    = 3,
    parameter int X_BW = 8,
    parameter int W_BW = 8,
    parameter int I_BW = 19,
    parameter int O_BW = 19,
    parameter int RELU = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_w_valid,
    output logic            o_w_ready,
    input  logic [W_BW-1:0] i_w,
    input  logic            i_w_load,
    input  logic            i_x_valid,
    output logic            o_x_ready,
    input  logic [X_BW-1:0] i_x,
    input  logic [I_BW-1:0] i_psum,
    output logic            o_y_valid,
    input  logic            i_y_ready,
    output logic [O_BW-1:0] o_y,
    output logic            o_sat
);

    localparam int c_n      = K * K;
    localparam int c_acc_bw = acc_bw(K, X_BW, W_BW);
    localparam int c_p_bw   = X_BW + W_BW;
    localparam int c_s_bw   = max_int(c_acc_bw, I_BW) + 1;
    localparam int c_cnt_bw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cnt_bw-1:0] c_last = c_cnt_bw'(c_n - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_cnt_bw-1:0]        r_wcnt;
    logic [c_cnt_bw-1:0]        r_xcnt;
    logic [W_BW-1:0]            r_w [c_n];

    logic                       w_en;
    logic                       w_w_fire;
    logic                       w_x_fire;
    logic signed [c_p_bw-1:0]   w_p;

    logic                       r_p_valid;
    logic                       r_p_first;
    logic                       r_p_last;
    logic signed [c_p_bw-1:0]   r_p;
    logic [I_BW-1:0]            r_psum;
    logic signed [c_acc_bw-1:0] r_acc;

    logic signed [c_acc_bw-1:0] w_acc_base;
    logic signed [c_acc_bw-1:0] w_acc_sum;
    logic signed [c_s_bw-1:0]   w_sum;
    logic [O_BW-1:0]            w_y;
    logic                       w_sat;

    // The whole pipe freezes only while a result waits on downstream.
    assign w_en     = !(o_y_valid && !i_y_ready);
    assign w_w_fire = i_w_valid && o_w_ready;
    assign w_x_fire = i_x_valid && o_x_ready;
    assign w_p      = $signed(i_x) * $signed(r_w[r_xcnt]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (i_w_valid && r_wcnt == c_last) w_state_nxt = S_RUN;
            S_RUN:   if (i_w_load && r_xcnt == '0) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_p_valid && !o_y_valid) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        o_w_ready = 1'b0;
        o_x_ready = 1'b0;
        case (r_state)
            S_LOAD:  o_w_ready = 1'b1;
            // A reload request is honoured only on a window boundary.
            S_RUN:   o_x_ready = w_en && !(i_w_load && r_xcnt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wcnt <= '0;
        end else if (w_w_fire) begin
            r_wcnt <= (r_wcnt == c_last) ? '0 : r_wcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_w_fire) begin
            r_w[r_wcnt] <= i_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xcnt    <= '0;
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_p       <= '0;
            r_psum    <= '0;
        end else if (w_en) begin
            r_p_valid <= w_x_fire;
            if (w_x_fire) begin
                r_p       <= w_p;
                r_p_first <= (r_xcnt == '0);
                r_p_last  <= (r_xcnt == c_last);
                if (r_xcnt == c_last) begin
                    r_psum <= i_psum;
                end
                r_xcnt <= (r_xcnt == c_last) ? '0 : r_xcnt + 1'b1;
            end
        end
    end

    assign w_acc_base = r_p_first ? '0 : r_acc;
    assign w_acc_sum  = w_acc_base + c_acc_bw'(r_p);
    assign w_sum      = c_s_bw'(w_acc_sum) + c_s_bw'($signed(r_psum));

    conv_sat_relu #(
        .IN_BW (c_s_bw),
        .O_BW  (O_BW),
        .RELU  (RELU)
    ) u_sat_relu (
        .i_in  (w_sum),
        .o_out (w_y),
        .o_sat (w_sat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            o_y       <= '0;
            o_sat     <= 1'b0;
            o_y_valid <= 1'b0;
        end else if (w_en) begin
            if (r_p_valid) begin
                r_acc <= w_acc_sum;
            end
            if (r_p_valid && r_p_last) begin
                o_y       <= w_y;
                o_sat     <= w_sat;
                o_y_valid <= 1'b1;
            end else begin
                o_y       <= '0;
                o_sat     <= 1'b0;
                o_y_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
